// File: rtl/iram_arbiter_if.sv
// Core-side fetch request/grant/return bundle plus the IRAM read port, shared by the arbiter and its users.
// The master side drives requests, addresses and IRAM data. The slave side (the arbiter) drives grants, returns and the IRAM address.
interface iram_arbiter_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]    core_req;
    logic [16*NUM_CORES-1:0] core_addr;
    logic [NUM_CORES-1:0]    core_grant;
    logic [NUM_CORES-1:0]    core_rvalid;
    logic [15:0]             core_rdata;
    logic [15:0]             iram_addr;
    logic [15:0]             iram_rdata;
    logic                    busy;

    modport slave (
        input  core_req,
        input  core_addr,
        input  iram_rdata,
        output core_grant,
        output core_rvalid,
        output core_rdata,
        output iram_addr,
        output busy
    );

    modport master (
        output core_req,
        output core_addr,
        output iram_rdata,
        input  core_grant,
        input  core_rvalid,
        input  core_rdata,
        input  iram_addr,
        input  busy
    );
endinterface

// File: rtl/iram_arbiter.sv
// Round-robin IRAM fetch arbiter with bounded bursts: the grant is combinational in the request cycle, and rvalid follows one cycle later.
// There is no backpressure. A core holds core_req until it is granted, and a dropped request loses its grant in the same cycle.
module iram_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    iram_arbiter_if.slave bus
);
    localparam int              IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);
    localparam logic [3:0]      BURST_MAX = 4'(MAX_BURST);

    logic [IDX_W-1:0] owner;
    logic             owner_vld;
    logic [3:0]       burst_cnt;
    logic [IDX_W-1:0] rv_idx;
    logic             rv_vld;

    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] scan_idx;
    logic             scan_hit;
    logic             keep_owner;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;

    // The scan starts just past the owner and visits the owner last.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = owner;
        cand     = owner;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = IDX_W'((int'(owner) + k) % NUM_CORES);
            if (!scan_hit && bus.core_req[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    // After reset no owner has been established yet. The reset owner, NUM_CORES-1,
    // only seeds the scan so that core 0 gets first priority.
    assign keep_owner = owner_vld && bus.core_req[owner] && (burst_cnt < BURST_MAX);
    assign gnt_vld    = !rst && scan_hit;
    assign gnt_idx    = keep_owner ? owner : scan_idx;

    always_comb begin
        bus.core_grant = '0;
        bus.iram_addr  = 16'd0;
        if (gnt_vld) begin
            bus.core_grant[gnt_idx] = 1'b1;
            bus.iram_addr           = bus.core_addr[16*gnt_idx +: 16];
        end
    end

    assign bus.busy       = gnt_vld;
    assign bus.core_rdata = bus.iram_rdata;

    // rst masks the return, so a fetch caught by a reset is never delivered.
    always_comb begin
        bus.core_rvalid = '0;
        if (rv_vld && !rst) begin
            bus.core_rvalid[rv_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= LAST_IDX;
            owner_vld <= 1'b0;
            burst_cnt <= 4'd0;
            rv_vld    <= 1'b0;
            rv_idx    <= '0;
        end else begin
            rv_vld <= gnt_vld;
            rv_idx <= gnt_idx;
            if (gnt_vld) begin
                if (owner_vld && (gnt_idx == owner)) begin
                    if (burst_cnt < BURST_MAX) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end else begin
                    owner     <= gnt_idx;
                    owner_vld <= 1'b1;
                    burst_cnt <= 4'd1;
                end
            end else begin
                burst_cnt <= 4'd0;
            end
        end
    end

    a_grant_onehot0 : assert property (@(posedge clk) $onehot0(bus.core_grant));
    a_grant_when_req : assert property (@(posedge clk) disable iff (rst)
        (|bus.core_req) |-> $onehot(bus.core_grant));
    a_rvalid_onehot0 : assert property (@(posedge clk) $onehot0(bus.core_rvalid));
    a_burst_bound : assert property (@(posedge clk) disable iff (rst) burst_cnt <= BURST_MAX);
    a_busy_grant : assert property (@(posedge clk) bus.busy == (|bus.core_grant));
endmodule

// File: tb/tb_iram_arbiter.sv
// Drives directed and random traffic into iram_arbiter and compares it against a rule-level arbitration model and an IRAM scoreboard.
module tb_iram_arbiter;
    localparam int N     = 4;
    localparam int MB    = 4;
    localparam int BOUND = (N - 1) * MB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    iram_arbiter_if #(.NUM_CORES(N)) bus ();

    iram_arbiter #(.NUM_CORES(N), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:65535];
    always @(posedge clk) bus.iram_rdata <= ram[bus.iram_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Model state: who owns the port, how many back-to-back grants it has had,
    // and whether anyone has owned it since reset.
    int          m_owner;
    int          m_cnt;
    bit          m_fresh;
    bit          pend_vld;
    int          pend_core;
    logic [15:0] pend_data;
    int          wait_cnt [N];
    int          max_wait;

    logic [N-1:0] obs_gnt;
    logic [N-1:0] obs_rv;
    logic [15:0]  obs_addr;
    logic [15:0]  obs_rdata;

    function automatic int pick(input logic [N-1:0] req);
        if (req == '0) return -1;
        if (!m_fresh && req[m_owner] && m_cnt < MB) return m_owner;
        for (int k = 1; k <= N; k++) begin
            if (req[(m_owner + k) % N]) return (m_owner + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [16*N-1:0] rand_addr();
        logic [16*N-1:0] v;
        for (int c = 0; c < N; c++) v[16*c +: 16] = 16'($urandom);
        return v;
    endfunction

    task automatic cycle(input bit r, input logic [N-1:0] req, input logic [16*N-1:0] addr);
        int           g;
        logic [N-1:0] e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.core_req  = req;
        bus.core_addr = addr;
        #1;
        obs_gnt   = bus.core_grant;
        obs_rv    = bus.core_rvalid;
        obs_addr  = bus.iram_addr;
        obs_rdata = bus.core_rdata;

        e = '0;
        if (pend_vld && !r) e[pend_core] = 1'b1;
        check("rvalid", 32'(obs_rv), 32'(e));
        if (pend_vld && !r) check("rdata", 32'(obs_rdata), 32'(pend_data));

        g = r ? -1 : pick(req);
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        check("grant", 32'(obs_gnt), 32'(e));
        check("busy", 32'(bus.busy), (g >= 0) ? 32'd1 : 32'd0);
        check("iram_addr", 32'(obs_addr), (g >= 0) ? 32'(addr[16*g +: 16]) : 32'd0);

        for (int c = 0; c < N; c++) begin
            if (r || !req[c] || obs_gnt[c]) begin
                wait_cnt[c] = 0;
            end else begin
                wait_cnt[c]++;
                if (wait_cnt[c] > max_wait) max_wait = wait_cnt[c];
            end
        end

        if (r) begin
            m_owner  = N - 1;
            m_cnt    = 0;
            m_fresh  = 1'b1;
            pend_vld = 1'b0;
        end else begin
            pend_vld = (g >= 0);
            if (g >= 0) begin
                pend_core = g;
                pend_data = ram[addr[16*g +: 16]];
                if (!m_fresh && g == m_owner) begin
                    m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                end else begin
                    m_owner = g;
                    m_cnt   = 1;
                    m_fresh = 1'b0;
                end
            end else begin
                m_cnt = 0;
            end
        end
    endtask

    initial begin
        logic [16*N-1:0] a;
        logic [N-1:0]    rq;
        bit              rr;
        for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
        ram[5]        = 16'd45;
        bus.core_req  = '0;
        bus.core_addr = '0;
        m_owner       = N - 1;
        m_cnt         = 0;
        m_fresh       = 1'b1;
        pend_vld      = 1'b0;
        pend_core     = 0;
        pend_data     = '0;
        max_wait      = 0;
        for (int c = 0; c < N; c++) wait_cnt[c] = 0;

        // Grants stay low under reset even with every core requesting.
        repeat (3) cycle(1'b1, 4'b1111, rand_addr());
        check("rst_grant", 32'(obs_gnt), 32'd0);

        // With all cores requesting, each core gets MB grants before the next core.
        for (int i = 0; i < 5 * N * MB; i++) begin
            cycle(1'b0, 4'b1111, rand_addr());
            check("rr_seq", 32'(obs_gnt), 32'(1) << ((i / MB) % N));
        end

        // A single fetch from core 2 returns its IRAM word on the next cycle.
        cycle(1'b0, 4'b0000, rand_addr());
        a = rand_addr();
        a[32 +: 16] = 16'd5;
        cycle(1'b0, 4'b0100, a);
        check("c2_grant", 32'(obs_gnt), 32'h4);
        check("c2_addr", 32'(obs_addr), 32'd5);
        cycle(1'b0, 4'b0000, rand_addr());
        check("c2_rvalid", 32'(obs_rv), 32'h4);
        check("c2_rdata", 32'(obs_rdata), 32'd45);

        // A lone requester streams without bubbles. A newcomer then wins once the burst is spent.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'b0010, rand_addr());
            check("c1_alone", 32'(obs_gnt), 32'h2);
        end
        cycle(1'b0, 4'b1010, rand_addr());
        check("c3_join", 32'(obs_gnt), 32'h8);

        // An idle cycle keeps the owner and restarts its burst.
        cycle(1'b0, 4'b0000, rand_addr());
        repeat (2) begin
            cycle(1'b0, 4'b0001, rand_addr());
            check("c0_twice", 32'(obs_gnt), 32'h1);
        end
        cycle(1'b0, 4'b0000, rand_addr());
        cycle(1'b0, 4'b0011, rand_addr());
        check("owner_hold", 32'(obs_gnt), 32'h1);

        // A grant followed by reset: its return is discarded, and core 0 wins after release.
        cycle(1'b0, 4'b1000, rand_addr());
        check("c3_grant", 32'(obs_gnt), 32'h8);
        cycle(1'b1, 4'b1111, rand_addr());
        check("rst_rvalid", 32'(obs_rv), 32'd0);
        check("rst_nogrant", 32'(obs_gnt), 32'd0);
        cycle(1'b1, 4'b1111, rand_addr());
        cycle(1'b0, 4'b1111, rand_addr());
        check("post_rst", 32'(obs_gnt), 32'h1);
        cycle(1'b0, 4'b0000, rand_addr());
        check("post_rst_rv", 32'(obs_rv), 32'h1);

        for (int c = 0; c < N; c++) wait_cnt[c] = 0;
        max_wait = 0;
        for (int i = 0; i < 10000; i++) begin
            rr = ($urandom_range(0, 999) == 0);
            for (int c = 0; c < N; c++) rq[c] = ($urandom_range(0, 99) < 55);
            cycle(rr, rq, rand_addr());
        end
        cycle(1'b0, 4'b0000, rand_addr());
        check("starve", (max_wait <= BOUND) ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iram_arbiter.md
IRAM_ARBITER -- requirements
Module: iram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of requesting cores, range 2..8.
REQ-002 SHALL have parameter MAX_BURST, default 4: maximum consecutive grants to one core while another core is requesting, range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock for all logic; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port core_req, input, NUM_CORES: bit i high = core i requests an instruction fetch this cycle.
REQ-006 SHALL have port core_addr, input, 16*NUM_CORES: fetch address of core i in bits [16*i+15:16*i].
REQ-007 SHALL have port core_grant, output, NUM_CORES: one-hot or zero; bit i high = core i's address is issued to IRAM this cycle.
REQ-008 SHALL have port core_rvalid, output, NUM_CORES: one-hot or zero; bit i high = core_rdata holds core i's instruction this cycle.
REQ-009 SHALL have port core_rdata, output, 16: instruction word, broadcast to all cores.
REQ-010 SHALL have port iram_addr, output, 16: read address to the IRAM.
REQ-011 SHALL have port iram_rdata, input, 16: IRAM data output, registered inside IRAM (1-cycle read latency).
REQ-012 SHALL have port busy, output, 1: high when any core_grant bit is high.

Function
REQ-013 SHALL compute core_grant, iram_addr, busy combinationally from core_req and registered state in the same cycle.
REQ-014 SHALL assert at most one core_grant bit per cycle, and exactly one whenever core_req != 0 and rst = 0.
REQ-015 SHALL drive iram_addr = address of the granted core; 16'd0 when no grant.
REQ-016 SHALL register the granted index; core_rvalid[i] SHALL be high exactly one cycle after core_grant[i].
REQ-017 SHALL drive core_rdata = iram_rdata continuously (pass-through, no extra register).
REQ-018 SHALL keep registers owner (index of last granted core) and burst_cnt (4 bits).
REQ-019 Arbitration: if core_req[owner] = 1 and burst_cnt < MAX_BURST, grant owner; otherwise grant first requesting core scanning owner+1, owner+2, ... wrapping modulo NUM_CORES, owner included last.
REQ-020 When the grant goes to owner, burst_cnt SHALL increment, saturating at MAX_BURST.
REQ-021 When the grant goes to a core other than owner, owner SHALL update to that core and burst_cnt SHALL load 1.
REQ-022 If burst_cnt = MAX_BURST and owner is the only requester, owner SHALL be granted (wrap-around scan) and burst_cnt SHALL remain MAX_BURST.
REQ-023 Idle cycle (core_req = 0): owner SHALL hold; burst_cnt SHALL clear to 0; core_rvalid next cycle = 0.
REQ-024 A core deasserting core_req while granted SHALL lose the grant that same cycle; its in-flight rvalid SHALL still be delivered.
REQ-025 Back-to-back grants SHALL sustain one fetch per cycle with no bubble, including across owner changes.
REQ-026 core_addr of non-granted cores SHALL have no effect on any output or state.

Reset
REQ-027 While rst = 1: core_grant = 0, busy = 0, iram_addr = 0, regardless of core_req.
REQ-028 At the clock edge with rst = 1: owner <= NUM_CORES-1 (core 0 first priority), burst_cnt <= 0, core_rvalid <= 0.
REQ-029 A grant issued in the cycle before a reset edge SHALL be discarded: core_rvalid = 0 in the cycle after that edge.
REQ-030 First cycle after rst falls SHALL arbitrate per REQ-019 with owner = NUM_CORES-1.

Verification
REQ-031 Reset, then core_req=4'b1111 held -> grants core0 x4, core1 x4, core2 x4, core3 x4, core0...; rvalid trails grant by exactly 1 cycle.
REQ-032 IRAM preloaded ram[5]=16'd45; core2 alone requests addr 5 for 1 cycle -> core_grant=4'b0100, iram_addr=5; next cycle core_rvalid=4'b0100, core_rdata=16'd45.
REQ-033 Only core1 requests for 10 cycles -> granted all 10 cycles, burst_cnt saturates at 4, no bubble; then core3 joins -> core3 granted next cycle.
REQ-034 core0 granted twice, core_req drops to 0 for 1 cycle, then core0 and core1 request -> core0 wins (owner held, burst_cnt restarted from 0).
REQ-035 core3 granted at cycle t, rst=1 at edge t+1 -> core_rvalid=0 at t+1, no grants while rst high; after release core0 wins when all request.
REQ-036 Random core_req/core_addr, 10k cycles, scoreboard vs IRAM model -> every granted address returns matching data to the correct core exactly once; no core starved longer than (NUM_CORES-1)*MAX_BURST cycles.
